uart_rx_tx_fifo: RTL and testbench

- Byte buffer and transmit scheduler between the uart_rx receiver and the uart_tx transmitter in the loopback path.
- Accepts each received byte on the receiver's done pulse and stores it in a circular FIFO.
- Drains the FIFO one byte at a time into the transmitter using an enable-pulse / done-pulse handshake.
- Replaces fixed character-time waiting with buffering, so back-to-back received characters are echoed without loss up to DEPTH.

---
 rtl/uart_rx_tx_fifo.sv | 139 +++++++++++++
 tb/tb_uart_rx_tx_fifo.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_tx_fifo.sv
// Byte FIFO between uart_rx and uart_tx: buffers each received byte and drains
// them in arrival order through a launch/done handshake with a bounded wait.
module uart_rx_tx_fifo #(
    parameter int DEPTH          = 16,
    parameter int ADDR_W         = 4,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic [7:0]        i_rx_byte,
    input  logic              i_rx_done,
    output logic [7:0]        o_tx_byte,
    output logic              o_tx_enable,
    input  logic              i_tx_done,
    output logic [ADDR_W:0]   o_fifo_count,
    output logic              o_tx_busy,
    output logic              o_overflow,
    output logic              o_tx_timeout
);

    localparam int                TMR_W      = $clog2(TIMEOUT_CYCLES);
    localparam logic [ADDR_W:0]   C_FULL     = (ADDR_W + 1)'(DEPTH);
    localparam logic [TMR_W-1:0]  C_TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1
    } state_t;

    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    state_t            r_state;
    logic [TMR_W-1:0]  r_timer;
    logic [7:0]        r_tx_byte;
    logic              r_tx_enable;
    logic              r_tx_busy;
    logic              r_overflow;
    logic              r_tx_timeout;

    logic              w_pop;
    logic              w_push;
    logic              w_drop;

    // A pop needs a byte present before the edge, so a push into an empty
    // FIFO is never popped on the same edge; a full FIFO can accept a byte
    // only when a pop frees a slot on that same edge.
    assign w_pop  = (r_state == S_IDLE) && (r_count != '0);
    assign w_push = i_rx_done && ((r_count != C_FULL) || w_pop);
    assign w_drop = i_rx_done && !w_push;

    // NOTE: the storage array has no reset; clearing the pointers and count
    // already discards its contents, and a reset on the array would prevent
    // it from mapping onto RAM.
    always_ff @(posedge i_clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_rx_byte;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_tx_byte    <= '0;
            r_tx_enable  <= 1'b0;
            r_tx_busy    <= 1'b0;
            r_tx_timeout <= 1'b0;
        end else begin
            // NOTE: the launch strobe defaults low every cycle, so it can only
            // ever be a single-cycle pulse no matter which branch runs below.
            r_tx_enable <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_tx_byte   <= r_mem[r_rd_ptr];
                        r_tx_enable <= 1'b1;
                        r_tx_busy   <= 1'b1;
                        r_timer     <= '0;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (i_tx_done) begin
                        r_tx_busy <= 1'b0;
                        r_timer   <= '0;
                        r_state   <= S_IDLE;
                    end else if (r_timer == C_TMR_LAST) begin
                        // Transmitter never answered: abandon this byte.
                        r_tx_timeout <= 1'b1;
                        r_tx_busy    <= 1'b0;
                        r_timer      <= '0;
                        r_state      <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: begin
                    r_tx_busy <= 1'b0;
                    r_timer   <= '0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign o_tx_byte    = r_tx_byte;
    assign o_tx_enable  = r_tx_enable;
    assign o_fifo_count = r_count;
    assign o_tx_busy    = r_tx_busy;
    assign o_overflow   = r_overflow;
    assign o_tx_timeout = r_tx_timeout;

endmodule

// File: tb/tb_uart_rx_tx_fifo.sv
// Bench for uart_rx_tx_fifo: directed stimulus pushes expected transmit bytes
// into a scoreboard queue; a negedge monitor pops and compares on every launch.
module tb_uart_rx_tx_fifo;

    localparam int DEPTH          = 16;
    localparam int ADDR_W         = 4;
    localparam int TIMEOUT_CYCLES = 10000;

    logic              clock = 1'b0;
    logic              reset;
    logic [7:0]        rx_byte;
    logic              rx_done;
    logic [7:0]        tx_byte;
    logic              tx_enable;
    logic              tx_done;
    logic [ADDR_W:0]   fifo_count;
    logic              tx_busy;
    logic              overflow;
    logic              tx_timeout;

    always #5 clock = ~clock;

    uart_rx_tx_fifo #(
        .DEPTH          (DEPTH),
        .ADDR_W         (ADDR_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .i_clock      (clock),
        .i_reset      (reset),
        .i_rx_byte    (rx_byte),
        .i_rx_done    (rx_done),
        .o_tx_byte    (tx_byte),
        .o_tx_enable  (tx_enable),
        .i_tx_done    (tx_done),
        .o_fifo_count (fifo_count),
        .o_tx_busy    (tx_busy),
        .o_overflow   (overflow),
        .o_tx_timeout (tx_timeout)
    );

    logic [7:0] exp_q[$];
    logic [7:0] exp_b;
    int         n_vec    = 0;
    int         n_miss   = 0;
    int         n_launch = 0;
    logic       prev_en  = 1'b0;

    // Scoreboard monitor: every launch must be a single-cycle pulse carrying
    // the oldest byte still expected.
    always @(negedge clock) begin
        if (tx_enable === 1'b1) begin
            n_launch++;
            n_vec++;
            if (prev_en) begin
                n_miss++;
                $display("FAIL launch_pulse: tx_enable high two cycles running, required one-cycle pulse");
            end else if (exp_q.size() == 0) begin
                n_miss++;
                $display("FAIL unexpected_launch: tx_byte=%02h launched, required no launch", tx_byte);
            end else begin
                exp_b = exp_q.pop_front();
                if (tx_byte !== exp_b) begin
                    n_miss++;
                    $display("FAIL launch_byte: tx_byte=%02h, required %02h", tx_byte, exp_b);
                end
            end
        end
        prev_en = (tx_enable === 1'b1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic rx(input logic [7:0] b, input bit sent);
        rx_byte = b;
        rx_done = 1'b1;
        if (sent) exp_q.push_back(b);
        step();
        rx_done = 1'b0;
    endtask

    task automatic pulse_done();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) step();
        reset = 1'b1;
        step();
    endtask

    task automatic wait_busy(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (tx_busy === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, "_busy_seen"}, 32'(ok), 32'd1);
        step();
    endtask

    // Serve n launches; each one must stay alone until its tx_done arrives.
    task automatic drain(input int n, input string name);
        int l0;
        for (int i = 0; i < n; i++) begin
            wait_busy(name);
            l0 = n_launch;
            repeat (3) step();
            check({name, "_no_launch_before_done"}, 32'(n_launch - l0), 32'd0);
            pulse_done();
        end
        repeat (3) step();
        check({name, "_idle"}, 32'(tx_busy), 32'd0);
        check({name, "_empty"}, 32'(fifo_count), 32'd0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_tx_byte"},    32'(tx_byte),    32'd0);
        check({name, "_tx_enable"},  32'(tx_enable),  32'd0);
        check({name, "_fifo_count"}, 32'(fifo_count), 32'd0);
        check({name, "_tx_busy"},    32'(tx_busy),    32'd0);
        check({name, "_overflow"},   32'(overflow),   32'd0);
        check({name, "_tx_timeout"}, 32'(tx_timeout), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int mx;
        int c;
        int l0;
        bit got;

        rx_byte = 8'h00;
        rx_done = 1'b0;
        tx_done = 1'b0;
        reset   = 1'b1;
        #1 reset = 1'b0;
        #1;
        check_all_zero("reset_initial");
        step();
        step();
        reset = 1'b1;
        step();

        // Single byte: count 1 after k, launch after k+1, busy until tx_done.
        rx(8'h41, 1'b1);
        check("single_count_after_push", 32'(fifo_count), 32'd1);
        check("single_no_launch_yet",    32'(tx_enable),  32'd0);
        step();
        check("single_launch",           32'(tx_enable),  32'd1);
        check("single_tx_byte",          32'(tx_byte),    32'h41);
        check("single_count_after_pop",  32'(fifo_count), 32'd0);
        check("single_busy",             32'(tx_busy),    32'd1);
        step();
        check("single_pulse_ends",       32'(tx_enable),  32'd0);
        step();
        check("single_busy_held",        32'(tx_busy),    32'd1);
        check("single_tx_byte_held",     32'(tx_byte),    32'h41);
        pulse_done();
        check("single_busy_cleared",     32'(tx_busy),    32'd0);
        repeat (2) step();

        // Burst of five back-to-back bytes with tx_done held off.
        mx = 0;
        for (int i = 0; i < 5; i++) begin
            rx(8'h10 + 8'(i), 1'b1);
            if (int'(fifo_count) > mx) mx = int'(fifo_count);
        end
        check("burst_peak_count", 32'(mx), 32'd4);
        drain(5, "burst");

        // Overflow: 18 bytes with no tx_done; only the last one is lost.
        for (int i = 0; i < 18; i++) begin
            rx(8'h20 + 8'(i), (i < 17));
            if (i == 16) begin
                check("ovf_full_count",    32'(fifo_count), 32'd16);
                check("ovf_not_yet",       32'(overflow),   32'd0);
            end
        end
        check("ovf_count_held", 32'(fifo_count), 32'd16);
        check("ovf_set",        32'(overflow),   32'd1);
        drain(17, "ovf");
        check("ovf_sticky",     32'(overflow),   32'd1);

        // Full FIFO, pop and push on the same edge.
        do_reset();
        check("full_reset_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 17; i++) rx(8'h50 + 8'(i), 1'b1);
        check("full_count",     32'(fifo_count), 32'd16);
        pulse_done();
        rx(8'hAA, 1'b1);
        check("full_simul_ovf",    32'(overflow),   32'd0);
        check("full_simul_count",  32'(fifo_count), 32'd16);
        check("full_simul_launch", 32'(tx_enable),  32'd1);
        drain(17, "full");

        // Timeout: no tx_done at all for the first byte.
        do_reset();
        rx(8'h70, 1'b1);
        rx(8'h71, 1'b1);
        @(negedge clock);
        check("to_first_launch", 32'(tx_enable), 32'd1);
        c   = 0;
        got = 1'b0;
        for (int i = 0; i < TIMEOUT_CYCLES + 5; i++) begin
            @(negedge clock);
            c++;
            if (tx_timeout === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        check("to_flag_seen",    32'(got), 32'd1);
        check("to_flag_cycle",   32'(c),   32'(TIMEOUT_CYCLES));
        check("to_busy_dropped", 32'(tx_busy), 32'd0);
        @(negedge clock);
        check("to_next_launch",  32'(tx_enable), 32'd1);
        step();
        pulse_done();
        check("to_second_done",  32'(tx_busy),    32'd0);
        check("to_sticky",       32'(tx_timeout), 32'd1);
        check("to_empty",        32'(fifo_count), 32'd0);

        // Reset in the middle of a wait with three bytes queued.
        do_reset();
        rx(8'h80, 1'b1);
        rx(8'h81, 1'b0);
        rx(8'h82, 1'b0);
        rx(8'h83, 1'b0);
        check("mid_count_before", 32'(fifo_count), 32'd3);
        check("mid_busy_before",  32'(tx_busy),    32'd1);
        #2 reset = 1'b0;
        #1;
        check_all_zero("mid_reset");
        step();
        step();
        reset = 1'b1;
        l0 = n_launch;
        repeat (20) step();
        check("mid_no_launch_after_release", 32'(n_launch - l0), 32'd0);
        check("mid_count_after_release",     32'(fifo_count),   32'd0);
        rx(8'h99, 1'b1);
        drain(1, "mid_recover");

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
